// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: sequencer states, redirect causes and the NOP encoding.
package fetch_pkg;

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, DROP} state_t;

  typedef enum logic [1:0] {RD_NONE, RD_BRANCH, RD_TRAP} redirect_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_sequencer_program_counter.sv
// Program-counter register with an active-high asynchronous reset.
module Program_Counter #(
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_prima,
  output logic [31:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= RESET_VALUE;
    else     pc <= pc_prima;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, sequences imem requests and delivers instr/pc to decode.
// state | meaning
// BOOT  | one idle cycle after reset, PC loaded from RESET_VECTOR
// FETCH | request outstanding at pc
// HOLD  | decode stalled, holding delivered instruction
// DROP  | redirected while a request was pending; discard that word
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        trap,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic        misaligned
);

  state_t      state;
  redirect_t   rd;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pc_d;
  logic [31:0] pend_pc;
  logic [31:0] target;
  logic        br_misaligned;

  always_comb begin
    rd = RD_NONE;
    if (state != BOOT) begin
      if (trap)              rd = RD_TRAP;
      else if (branch_taken) rd = RD_BRANCH;
    end
    br_misaligned = (branch_target[1:0] != 2'b00);
    target = (rd == RD_BRANCH && !br_misaligned) ? {branch_target[31:2], 2'b00} : TRAP_VECTOR;

    pc_next = pc;
    case (state)
      BOOT:  pc_next = RESET_VECTOR;
      FETCH: if (imem_ready) pc_next = (rd != RD_NONE) ? target : pc + 32'd4;
      HOLD:  if (rd != RD_NONE) pc_next = target;
      DROP:  if (imem_ready) pc_next = (rd != RD_NONE) ? target : pend_pc;
      default: pc_next = pc;
    endcase
  end

  // PC is kept word-aligned regardless of vector/target low bits
  assign pc_d = {pc_next[31:2], 2'b00};

  Program_Counter #(.RESET_VALUE(RESET_VECTOR)) u_pc (
    .clk      (clk),
    .rst      (~reset),
    .pc_prima (pc_d),
    .pc       (pc)
  );

  assign imem_req  = (state == FETCH) || (state == DROP);
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      pend_pc     <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      pc_out      <= '0;
      misaligned  <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      misaligned  <= (rd == RD_BRANCH) && br_misaligned;
      case (state)
        BOOT: state <= FETCH;
        FETCH: begin
          if (rd != RD_NONE) begin
            if (!imem_ready) begin
              pend_pc <= {target[31:2], 2'b00};
              state   <= DROP;
            end
          end else if (imem_ready) begin
            instr       <= imem_rdata;
            pc_out      <= pc;
            instr_valid <= 1'b1;
            state       <= stall ? HOLD : FETCH;
          end
        end
        HOLD: begin
          if (rd != RD_NONE || !stall) state <= FETCH;
          else                         instr_valid <= 1'b1;
        end
        DROP: begin
          if (rd != RD_NONE) pend_pc <= {target[31:2], 2'b00};
          if (imem_ready)    state   <= FETCH;
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a per-cycle expectation scoreboard.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, branch_taken, trap, imem_ready;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, misaligned;
  logic [31:0] instr, pc_out;

  localparam logic [31:0] TAG = 32'hC0DE_0000;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ TAG;

  fetch_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .trap          (trap),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .pc_out        (pc_out),
    .misaligned    (misaligned)
  );

  function automatic exp_t mk(input logic req, input logic [31:0] addr, input logic valid,
                              input logic [31:0] pc, input logic mis);
    exp_t e;
    e.req = req; e.addr = addr; e.valid = valid; e.pc = pc; e.mis = mis;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare(input exp_t e);
    chk($sformatf("c%0d imem_req", cyc), {31'd0, imem_req}, {31'd0, e.req});
    if (e.req) chk($sformatf("c%0d imem_addr", cyc), imem_addr, e.addr);
    chk($sformatf("c%0d instr_valid", cyc), {31'd0, instr_valid}, {31'd0, e.valid});
    if (e.valid) begin
      chk($sformatf("c%0d pc_out", cyc), pc_out, e.pc);
      chk($sformatf("c%0d instr", cyc), instr, e.pc ^ TAG);
    end
    chk($sformatf("c%0d misaligned", cyc), {31'd0, misaligned}, {31'd0, e.mis});
  endtask

  // drive one cycle of inputs, queue its expected outputs, compare on the falling edge
  task automatic step(input logic st, input logic br, input logic tr, input logic rdy,
                      input logic [31:0] tgt, input exp_t e);
    stall = st; branch_taken = br; trap = tr; imem_ready = rdy; branch_target = tgt;
    sb.push_back(e);
    @(negedge clk);
    cyc++;
    compare(sb.pop_front());
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; trap = 1'b0;
    imem_ready = 1'b0; branch_target = '0;
    #2;
    chk("rst imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst instr", instr, 32'd0);
    chk("rst pc_out", pc_out, 32'd0);
    chk("rst misaligned", {31'd0, misaligned}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    //    stall br tr rdy target          req addr          valid pc            mis
    step(0, 0, 0, 1, 32'h0,          mk(0, 32'h0,         0, 32'h0,         0)); // BOOT
    step(0, 0, 0, 1, 32'h0,          mk(1, 32'h0,         0, 32'h0,         0));
    step(0, 0, 0, 1, 32'h0,          mk(1, 32'h4,         1, 32'h0,         0));
    step(1, 0, 0, 1, 32'h0,          mk(1, 32'h8,         1, 32'h4,         0)); // capture 8 under stall
    step(1, 0, 0, 1, 32'h0,          mk(0, 32'h0,         1, 32'h8,         0)); // HOLD
    step(1, 0, 0, 1, 32'h0,          mk(0, 32'h0,         1, 32'h8,         0));
    step(0, 0, 0, 1, 32'h0,          mk(0, 32'h0,         1, 32'h8,         0));
    step(0, 0, 0, 1, 32'h0,          mk(1, 32'hC,         0, 32'h0,         0));
    step(0, 0, 0, 0, 32'h0,          mk(1, 32'h10,        1, 32'hC,         0)); // ready low x4
    step(0, 1, 0, 0, 32'h200,        mk(1, 32'h10,        0, 32'h0,         0)); // branch -> DROP
    step(1, 0, 0, 0, 32'h0,          mk(1, 32'h10,        0, 32'h0,         0));
    step(0, 0, 0, 0, 32'h0,          mk(1, 32'h10,        0, 32'h0,         0));
    step(0, 0, 0, 1, 32'h0,          mk(1, 32'h10,        0, 32'h0,         0)); // word discarded
    step(0, 0, 0, 1, 32'h0,          mk(1, 32'h200,       0, 32'h0,         0));
    step(0, 1, 1, 1, 32'h400,        mk(1, 32'h204,       1, 32'h200,       0)); // trap beats branch
    step(0, 0, 0, 1, 32'h0,          mk(1, 32'h100,       0, 32'h0,         0));
    step(0, 1, 0, 1, 32'h202,        mk(1, 32'h104,       1, 32'h100,       0)); // misaligned target
    step(0, 0, 0, 1, 32'h0,          mk(1, 32'h100,       0, 32'h0,         1));
    step(1, 0, 0, 1, 32'h0,          mk(1, 32'h104,       1, 32'h100,       0));
    step(1, 1, 0, 1, 32'h300,        mk(0, 32'h0,         1, 32'h104,       0)); // redirect in HOLD
    step(0, 0, 0, 1, 32'h0,          mk(1, 32'h300,       0, 32'h0,         0));
    step(0, 1, 0, 1, 32'hFFFF_FFFC,  mk(1, 32'h304,       1, 32'h300,       0));
    step(0, 0, 0, 1, 32'h0,          mk(1, 32'hFFFF_FFFC, 0, 32'h0,         0));
    step(0, 0, 0, 1, 32'h0,          mk(1, 32'h0,         1, 32'hFFFF_FFFC, 0)); // wrap
    step(0, 0, 0, 1, 32'h0,          mk(1, 32'h4,         1, 32'h0,         0));

    // asynchronous reset mid-request, between clock edges
    chk("pre-reset imem_req", {31'd0, imem_req}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async imem_req", {31'd0, imem_req}, 32'd0);
    chk("async instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("async pc_out", pc_out, 32'd0);
    chk("async instr", instr, 32'd0);
    chk("async imem_addr", imem_addr, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    step(0, 1, 1, 1, 32'h400,        mk(0, 32'h0,         0, 32'h0,         0)); // BOOT ignores redirect
    step(0, 0, 0, 1, 32'h0,          mk(1, 32'h0,         0, 32'h0,         0));
    step(0, 0, 0, 1, 32'h0,          mk(1, 32'h4,         1, 32'h0,         0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
